alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_pkg.sv | 93 +++++++++
 rtl/rv32ialu.sv | 29 ++
 rtl/alu_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants, types and the instruction decoder for the ALU issue
// front end and its rv32ialu datapath.
package alu_issue_pkg;

  localparam logic [2:0] ALU_SUB  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4
  } br_kind_e;

  typedef struct packed {
    logic [2:0] ctrl;
    logic       use_imm;
    br_kind_e   br_kind;
    logic       illegal;
  } decode_t;

  function automatic decode_t decode(input logic [6:0] opcode,
                                     input logic [2:0] f3,
                                     input logic [6:0] f7);
    decode_t d;
    d.ctrl    = ALU_RSVD;
    d.use_imm = 1'b0;
    d.br_kind = BR_NONE;
    d.illegal = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          d.illegal = 1'b0;
          unique case (f3)
            3'b000:  d.ctrl = ALU_ADD;
            3'b001:  d.ctrl = ALU_SLL;
            3'b010:  d.ctrl = ALU_SLT;
            3'b101:  d.ctrl = ALU_SRL;
            3'b110:  d.ctrl = ALU_OR;
            3'b111:  d.ctrl = ALU_AND;
            default: d.illegal = 1'b1;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.ctrl    = ALU_SUB;
          d.illegal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        d.use_imm = 1'b1;
        d.illegal = 1'b0;
        unique case (f3)
          3'b000:  d.ctrl = ALU_ADD;
          3'b010:  d.ctrl = ALU_SLT;
          3'b110:  d.ctrl = ALU_OR;
          3'b111:  d.ctrl = ALU_AND;
          3'b001:  if (f7 == 7'b0000000) d.ctrl = ALU_SLL; else d.illegal = 1'b1;
          3'b101:  if (f7 == 7'b0000000) d.ctrl = ALU_SRL; else d.illegal = 1'b1;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        d.illegal = 1'b0;
        unique case (f3)
          3'b000: begin d.ctrl = ALU_SUB; d.br_kind = BR_EQ; end
          3'b001: begin d.ctrl = ALU_SUB; d.br_kind = BR_NE; end
          3'b100: begin d.ctrl = ALU_SLT; d.br_kind = BR_LT; end
          3'b101: begin d.ctrl = ALU_SLT; d.br_kind = BR_GE; end
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    // Any illegal outcome must drive the reserved ALU op with no side info.
    if (d.illegal) begin
      d.ctrl    = ALU_RSVD;
      d.use_imm = 1'b0;
      d.br_kind = BR_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/rv32ialu.sv
// Combinational RV32I ALU subset driven by the 3-bit alu_ctrl encoding;
// the reserved encoding yields Y=0.
module rv32ialu
  import alu_issue_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  alu_ctrl,
  output logic [31:0] Y,
  output logic        zero
);

  always_comb begin
    Y = '0;
    unique case (alu_ctrl)
      ALU_SUB: Y = A - B;
      ALU_ADD: Y = A + B;
      ALU_AND: Y = A & B;
      ALU_OR:  Y = A | B;
      ALU_SLL: Y = A << B[4:0];
      ALU_SRL: Y = A >> B[4:0];
      ALU_SLT: Y = {31'd0, $signed(A) < $signed(B)};
      default: Y = '0;
    endcase
  end

  assign zero = (Y == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/retire front end: decode into S1 (execute, drives the ALU),
// capture ALU outputs into S2 and return them over a valid/ready handshake.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_rs1,
  input  logic [31:0]          in_rs2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_zero,
  output logic                 out_is_branch,
  output logic                 out_taken,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_ctrl_q, s1_ctrl_d;
  logic [31:0] s1_a_q, s1_a_d;
  logic [31:0] s1_b_q, s1_b_d;
  br_kind_e    s1_br_q, s1_br_d;
  logic        s1_ill_q, s1_ill_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_result_q, s2_result_d;
  logic        s2_zero_q, s2_zero_d;
  logic        s2_is_br_q, s2_is_br_d;
  logic        s2_taken_q, s2_taken_d;
  logic        s2_ill_q, s2_ill_d;

  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic        s1_adv, accept;
  decode_t     dec;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        taken;

  assign s1_adv   = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s1_adv;
  assign accept   = in_valid & in_ready;
  assign dec      = decode(in_instr[6:0], in_instr[14:12], in_instr[31:25]);

  rv32ialu u_alu (
    .A        (s1_a_q),
    .B        (s1_b_q),
    .alu_ctrl (s1_ctrl_q),
    .Y        (alu_y),
    .zero     (alu_zero)
  );

  always_comb begin
    taken = 1'b0;
    unique case (s1_br_q)
      BR_EQ:   taken = alu_zero;
      BR_NE:   taken = ~alu_zero;
      BR_LT:   taken = alu_y[0];
      BR_GE:   taken = ~alu_y[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ctrl_d  = s1_ctrl_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_br_d    = s1_br_q;
    s1_ill_d   = s1_ill_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_ctrl_d  = dec.ctrl;
      s1_a_d     = in_rs1;
      s1_b_d     = dec.use_imm ? {{20{in_instr[31]}}, in_instr[31:20]} : in_rs2;
      s1_br_d    = dec.br_kind;
      s1_ill_d   = dec.illegal;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Payload only reloads when S1 actually moves a valid op forward, so it
  // stays stable under backpressure and after a drain.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_is_br_d  = s2_is_br_q;
    s2_taken_d  = s2_taken_q;
    s2_ill_d    = s2_ill_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = alu_y;
        s2_zero_d   = alu_zero;
        s2_is_br_d  = (s1_br_q != BR_NONE);
        s2_taken_d  = taken;
        s2_ill_d    = s1_ill_q;
      end
    end
  end

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (s2_valid_q && out_ready && s2_ill_q && (ill_cnt_q != '1))
      ill_cnt_d = ill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_ctrl_q   <= ALU_RSVD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_br_q     <= BR_NONE;
      s1_ill_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_is_br_q  <= 1'b0;
      s2_taken_q  <= 1'b0;
      s2_ill_q    <= 1'b0;
      ill_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_br_q     <= s1_br_d;
      s1_ill_q    <= s1_ill_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_is_br_q  <= s2_is_br_d;
      s2_taken_q  <= s2_taken_d;
      s2_ill_q    <= s2_ill_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_result    = s2_result_q;
  assign out_zero      = s2_zero_q;
  assign out_is_branch = s2_is_br_q;
  assign out_taken     = s2_taken_q;
  assign out_illegal   = s2_ill_q;
  assign ill_cnt       = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with hand-computed results.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_is_branch;
  logic        out_taken;
  logic        out_illegal;
  logic [15:0] ill_cnt;

  int checks = 0;
  int errors = 0;
  int exp_ill = 0;

  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_SRLI = 32'h0040D093;
  localparam logic [31:0] I_SLT  = 32'h0020A033;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_BLT  = 32'h0020C063;
  localparam logic [31:0] I_BGE  = 32'h0020D063;
  localparam logic [31:0] I_XOR  = 32'h0020C033;
  localparam logic [31:0] I_BLTU = 32'h0020E063;
  localparam logic [31:0] I_MUL  = 32'h02208033;
  localparam logic [31:0] I_ADDI_M1 = 32'hFFF08093;

  alu_issue_ctrl #(.ILL_CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_is_branch (out_is_branch),
    .out_taken     (out_taken),
    .out_illegal   (out_illegal),
    .ill_cnt       (ill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int imm);
    logic [11:0] i12;
    i12 = imm[11:0];
    return {i12, 20'h08093};
  endfunction

  // Accept one op with out_ready=1, then advance so it sits in S2.
  task automatic run_one(input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_rs1    = a;
    in_rs2    = b;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (ill_cnt !== 16'h0) begin errors++; $display("FAIL reset_ill_cnt got %h want 0000", ill_cnt); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", out_result); end
  endtask

  task automatic test_rtype();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = I_SUB; in_rs1 = 32'd5; in_rs2 = 32'd7;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_latency1 got %0b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %0b want 1", out_valid); end
    checks++; if (out_result !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result got %h want fffffffe", out_result); end
    checks++; if ({out_zero, out_illegal, out_is_branch, out_taken} !== 4'b0000) begin
      errors++; $display("FAIL sub_flags got %b want 0000", {out_zero, out_illegal, out_is_branch, out_taken}); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got %0b want 0", out_valid); end
    run_one(I_SLT, 32'hFFFFFFFB, 32'd3);
    checks++; if (out_result !== 32'd1) begin errors++; $display("FAIL slt_result got %h want 1", out_result); end
    run_one(I_SLT, 32'd3, 32'hFFFFFFFB);
    checks++; if (out_result !== 32'd0 || out_zero !== 1'b1) begin
      errors++; $display("FAIL slt_false got %h/%0b want 0/1", out_result, out_zero); end
  endtask

  task automatic test_itype();
    run_one(I_SRLI, 32'h80000000, 32'hDEADBEEF);
    checks++; if (out_result !== 32'h08000000) begin errors++; $display("FAIL srli_result got %h want 08000000", out_result); end
    run_one(I_ADDI_M1, 32'd10, 32'd0);
    checks++; if (out_result !== 32'd9) begin errors++; $display("FAIL addi_neg got %h want 9", out_result); end
  endtask

  task automatic test_branch();
    run_one(I_BEQ, 32'h1234, 32'h1234);
    checks++; if ({out_is_branch, out_taken, out_zero} !== 3'b111) begin
      errors++; $display("FAIL beq got br/tk/z %b want 111", {out_is_branch, out_taken, out_zero}); end
    run_one(I_BGE, 32'hFFFFFFFF, 32'h0);
    checks++; if ({out_is_branch, out_taken} !== 2'b10 || out_result !== 32'd1) begin
      errors++; $display("FAIL bge got br/tk %b y %h want 10 y 1", {out_is_branch, out_taken}, out_result); end
    run_one(I_BNE, 32'd3, 32'd4);
    checks++; if ({out_is_branch, out_taken} !== 2'b11) begin
      errors++; $display("FAIL bne got %b want 11", {out_is_branch, out_taken}); end
    run_one(I_BLT, 32'd4, 32'd3);
    checks++; if ({out_is_branch, out_taken} !== 2'b10) begin
      errors++; $display("FAIL blt got %b want 10", {out_is_branch, out_taken}); end
  endtask

  task automatic test_illegal();
    logic [31:0] ill_tab [3];
    ill_tab[0] = I_XOR; ill_tab[1] = I_BLTU; ill_tab[2] = I_MUL;
    for (int i = 0; i < 3; i++) begin
      run_one(ill_tab[i], 32'hFFFF0000, 32'h0000FFFF);
      checks++; if ({out_illegal, out_zero, out_is_branch, out_taken} !== 4'b1100 || out_result !== 32'h0) begin
        errors++; $display("FAIL illegal_%0d got flags %b y %h want 1100 y 0", i,
                           {out_illegal, out_zero, out_is_branch, out_taken}, out_result); end
      checks++; if (ill_cnt !== 16'(exp_ill)) begin errors++; $display("FAIL ill_cnt_pre_%0d got %0d want %0d", i, ill_cnt, exp_ill); end
      step();
      exp_ill++;
      checks++; if (ill_cnt !== 16'(exp_ill)) begin errors++; $display("FAIL ill_cnt_post_%0d got %0d want %0d", i, ill_cnt, exp_ill); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    out_ready = 1'b0; in_valid = 1'b1; in_rs1 = 32'd100;
    in_instr = addi(1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %0b want 1", in_ready); end
    step();
    in_instr = addi(2);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_one_accept got rdy %0b ov %0b want 1 0", in_ready, out_valid); end
    step();
    in_instr = addi(3);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd101) begin
      errors++; $display("FAIL bp_full got rdy %0b ov %0b y %0d want 0 1 101", in_ready, out_valid, out_result); end
    step();
    checks++; if (in_ready !== 1'b0 || out_result !== 32'd101) begin
      errors++; $display("FAIL bp_hold got rdy %0b y %0d want 0 101", in_ready, out_result); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    exp_q = '{32'd102, 32'd103, 32'd104};
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) in_instr = addi(4);
      if (i == 1) in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== exp_q[i]) begin
        errors++; $display("FAIL bp_stream_%0d got ov %0b y %0d want 1 %0d", i, out_valid, out_result, exp_q[i]); end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_XOR; in_rs1 = 32'd1; in_rs2 = 32'd2;
    repeat (2) step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ill_cnt !== 16'h0 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL rst_async got ov %0b rdy %0b cnt %0d ill %0b want 0 1 0 0",
                         out_valid, in_ready, ill_cnt, out_illegal); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got ov %0b want 0", out_valid); end
    end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = I_XOR;
    repeat (100) step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (ill_cnt !== 16'd100) begin errors++; $display("FAIL sat_partial got %0d want 100", ill_cnt); end
    in_valid = 1'b1;
    repeat (65539 - 100) step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (ill_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_full got %h want ffff", ill_cnt); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
